// File: rtl/bus_cpu_core.sv
// Multicycle bus-based register processor: NREGS registers, accumulator A and
// result G share one one-hot muxed internal bus; flags, done/busy and debug read.
module bus_cpu_core #(
   parameter  int WIDTH  = 8,
   parameter  int NREGS  = 8,
   localparam int RSEL_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              w,
   input  logic [2:0]        func,
   input  logic [RSEL_W-1:0] rx,
   input  logic [RSEL_W-1:0] ry,
   input  logic [WIDTH-1:0]  data,
   input  logic [RSEL_W-1:0] dbg_sel,
   output logic [WIDTH-1:0]  dbg_val,
   output logic [WIDTH-1:0]  bus,
   output logic              busy,
   output logic              done,
   output logic              flag_z,
   output logic              flag_n
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_T1   = 2'd1;
   localparam logic [1:0] S_T2   = 2'd2;
   localparam logic [1:0] S_T3   = 2'd3;

   localparam logic [2:0] OP_LOAD = 3'd0;
   localparam logic [2:0] OP_MOVE = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_SUB  = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_AND  = 3'd5;
   localparam logic [2:0] OP_OR   = 3'd6;
   localparam logic [2:0] OP_CMP  = 3'd7;

   logic [1:0]        state;
   logic [2:0]        func_q;
   logic [RSEL_W-1:0] rx_q, ry_q;
   logic [WIDTH-1:0]  data_q;
   logic [WIDTH-1:0]  a_q, g_q;
   logic [WIDTH-1:0]  regs [NREGS];
   logic [WIDTH-1:0]  alu_res;
   logic              is_xfer;
   logic              sel_data, sel_rx, sel_ry, sel_g;

   // LOAD/MOVE finish in T1; everything else walks T1..T3
   assign is_xfer = (func_q == OP_LOAD) || (func_q == OP_MOVE);

   always_comb begin
      sel_data = 1'b0;
      sel_rx   = 1'b0;
      sel_ry   = 1'b0;
      sel_g    = 1'b0;
      case (state)
         S_T1: begin
            if (func_q == OP_LOAD)      sel_data = 1'b1;
            else if (func_q == OP_MOVE) sel_ry   = 1'b1;
            else                        sel_rx   = 1'b1;
         end
         S_T2:    sel_ry = 1'b1;
         S_T3:    sel_g  = 1'b1;
         default: ;
      endcase
   end

   // At most one select is high, so AND-OR is a clean mux and IDLE drives zero
   assign bus = ({WIDTH{sel_data}} & data_q)
              | ({WIDTH{sel_rx}}   & regs[rx_q])
              | ({WIDTH{sel_ry}}   & regs[ry_q])
              | ({WIDTH{sel_g}}    & g_q);

   always_comb begin
      alu_res = '0;
      case (func_q)
         OP_ADD:         alu_res = a_q + bus;
         OP_SUB, OP_CMP: alu_res = a_q + ~bus + WIDTH'(1);
         OP_XOR:         alu_res = a_q ^ bus;
         OP_AND:         alu_res = a_q & bus;
         OP_OR:          alu_res = a_q | bus;
         default:        alu_res = '0;
      endcase
   end

   assign busy    = (state != S_IDLE);
   assign done    = ((state == S_T1) && is_xfer) || (state == S_T3);
   assign dbg_val = regs[dbg_sel];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= S_IDLE;
         func_q <= '0;
         rx_q   <= '0;
         ry_q   <= '0;
         data_q <= '0;
         a_q    <= '0;
         g_q    <= '0;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (w) begin
                  func_q <= func;
                  rx_q   <= rx;
                  ry_q   <= ry;
                  data_q <= data;
                  state  <= S_T1;
               end
            end
            S_T1: begin
               if (is_xfer) begin
                  regs[rx_q] <= bus;
                  state      <= S_IDLE;
               end else begin
                  a_q   <= bus;
                  state <= S_T2;
               end
            end
            S_T2: begin
               g_q    <= alu_res;
               flag_z <= (alu_res == '0);
               flag_n <= alu_res[WIDTH-1];
               state  <= S_T3;
            end
            default: begin
               if (func_q != OP_CMP) regs[rx_q] <= bus;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_cpu_core.sv
// Scoreboard bench for bus_cpu_core: stimulus updates an instruction-level
// register model and queues expectations; a monitor checks each done pulse.
module tb_bus_cpu_core;
   localparam int W  = 8;
   localparam int NR = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          w = 1'b0;
   logic [2:0]    func = '0;
   logic [1:0]    rx = '0, ry = '0, dbg_sel = '0;
   logic [W-1:0]  data = '0;
   logic [W-1:0]  dbg_val, bus;
   logic          busy, done, flag_z, flag_n;

   bus_cpu_core #(.WIDTH(W), .NREGS(NR)) dut (
      .clk(clk), .reset(reset), .w(w), .func(func), .rx(rx), .ry(ry),
      .data(data), .dbg_sel(dbg_sel), .dbg_val(dbg_val), .bus(bus),
      .busy(busy), .done(done), .flag_z(flag_z), .flag_n(flag_n)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef logic [NR-1:0][W-1:0] snap_t;
   typedef struct {
      logic [W-1:0] val;
      logic         z;
      logic         n;
      int           lat;
      int           issue;
      snap_t        snap;
   } exp_t;

   exp_t         exp_q[$];
   snap_t        sweep_q[$];
   logic [W-1:0] mr [NR];
   logic         mz, mn;
   int           n_vec = 0, n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NR; i++) mr[i] = '0;
      mz = 1'b0;
      mn = 1'b0;
   endtask

   function automatic snap_t snap_now();
      snap_t s;
      for (int i = 0; i < NR; i++) s[i] = mr[i];
      return s;
   endfunction

   // Called at an IDLE negedge; returns at the following IDLE negedge.
   task automatic issue(input logic [2:0] f, input logic [1:0] x, input logic [1:0] y,
                        input logic [W-1:0] d, input bit junk);
      exp_t         e;
      logic [W-1:0] a, b, r;
      int           n;
      a = mr[x];
      b = mr[y];
      case (f)
         3'd0:    r = d;
         3'd1:    r = b;
         3'd2:    r = W'(a + b);
         3'd3:    r = W'(a - b);
         3'd4:    r = a ^ b;
         3'd5:    r = a & b;
         3'd6:    r = a | b;
         default: r = W'(a - b);
      endcase
      if (f >= 3'd2) begin
         mz = (r == '0);
         mn = r[W-1];
      end
      if (f != 3'd7) mr[x] = r;
      e.val   = r;
      e.z     = mz;
      e.n     = mn;
      e.lat   = (f <= 3'd1) ? 1 : 3;
      e.issue = cyc;
      e.snap  = snap_now();
      chk("idle_busy", 32'(busy), 32'(0));
      chk("idle_done", 32'(done), 32'(0));
      chk("idle_bus", 32'(bus), 32'(0));
      exp_q.push_back(e);
      w = 1'b1; func = f; rx = x; ry = y; data = d;
      n = 0;
      forever begin
         @(negedge clk);
         if (junk) begin
            w    = ~w;
            func = func + 3'd1;
            rx   = 2'($urandom_range(0, 3));
            ry   = 2'($urandom_range(0, 3));
            data = W'($urandom);
         end else begin
            w = 1'b0;
         end
         if (done) break;
         n++;
         if (n > 8) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: no done within 8 cycles, expected 1 or 3");
            break;
         end
      end
      @(negedge clk);
      w = 1'b0;
   endtask

   // Monitor: one register sweep per negedge, then check any done pulse
   initial begin
      exp_t         e;
      snap_t        s;
      logic         d, z, nf;
      logic [W-1:0] bv;
      forever begin
         @(negedge clk);
         d = done; bv = bus; z = flag_z; nf = flag_n;
         if (sweep_q.size() > 0) begin
            s = sweep_q.pop_front();
            for (int i = 0; i < NR; i++) begin
               dbg_sel = 2'(i);
               #1;
               chk($sformatf("dbg_r%0d", i), 32'(dbg_val), 32'(s[i]));
            end
         end
         if (d) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL spurious_done: done=1 with nothing outstanding, expected 0");
            end else begin
               e = exp_q.pop_front();
               chk("latency", 32'(cyc - e.issue), 32'(e.lat));
               chk("bus_at_done", 32'(bv), 32'(e.val));
               chk("flag_z", 32'(z), 32'(e.z));
               chk("flag_n", 32'(nf), 32'(e.n));
               sweep_q.push_back(e.snap);
            end
         end
      end
   end

   initial begin
      model_reset();
      reset = 1'b0; w = 1'b1; func = 3'd2; rx = 2'd1; ry = 2'd2; data = 8'h33;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_flag_z", 32'(flag_z), 32'(0));
      chk("rst_flag_n", 32'(flag_n), 32'(0));
      chk("rst_bus", 32'(bus), 32'(0));
      sweep_q.push_back(snap_now());
      @(negedge clk);
      reset = 1'b1; w = 1'b0;
      @(negedge clk);

      issue(3'd0, 2'd2, 2'd0, 8'h5A, 1'b0);
      issue(3'd0, 2'd0, 2'd0, 8'hF0, 1'b0);
      issue(3'd0, 2'd1, 2'd0, 8'h20, 1'b0);
      issue(3'd2, 2'd0, 2'd1, 8'h00, 1'b0);
      issue(3'd3, 2'd1, 2'd1, 8'h00, 1'b0);
      issue(3'd0, 2'd0, 2'd0, 8'h10, 1'b0);
      issue(3'd0, 2'd1, 2'd0, 8'h20, 1'b0);
      issue(3'd7, 2'd0, 2'd1, 8'h00, 1'b0);
      issue(3'd4, 2'd0, 2'd0, 8'h00, 1'b0);
      issue(3'd0, 2'd2, 2'd0, 8'hCC, 1'b0);
      issue(3'd0, 2'd3, 2'd0, 8'hAA, 1'b0);
      issue(3'd5, 2'd2, 2'd3, 8'h00, 1'b0);
      issue(3'd0, 2'd2, 2'd0, 8'hCC, 1'b0);
      issue(3'd6, 2'd2, 2'd3, 8'h00, 1'b0);
      issue(3'd0, 2'd3, 2'd0, 8'h7F, 1'b0);
      issue(3'd1, 2'd0, 2'd3, 8'h00, 1'b0);
      issue(3'd2, 2'd3, 2'd0, 8'h11, 1'b1);
      issue(3'd0, 2'd1, 2'd0, 8'h00, 1'b0);

      // Abort an ADD r1,r2 in T2
      w = 1'b1; func = 3'd2; rx = 2'd1; ry = 2'd2; data = 8'h00;
      @(negedge clk);
      w = 1'b0;
      chk("abort_t1_busy", 32'(busy), 32'(1));
      @(negedge clk);
      chk("abort_t2_busy", 32'(busy), 32'(1));
      chk("abort_t2_done", 32'(done), 32'(0));
      reset = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_done", 32'(done), 32'(0));
      chk("abort_bus", 32'(bus), 32'(0));
      chk("abort_flag_n", 32'(flag_n), 32'(0));
      chk("abort_flag_z", 32'(flag_z), 32'(0));
      reset = 1'b1;
      model_reset();
      sweep_q.push_back(snap_now());
      repeat (2) @(negedge clk);

      for (int k = 0; k < 60; k++)
         issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               W'($urandom), 1'($urandom_range(0, 1)));

      repeat (3) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bus_cpu_core.md
Name: bus_cpu_core

Overview:
- Parametrised successor to the small bus-based register processor: NREGS general registers, accumulator A and result register G share one WIDTH-bit internal bus.
- Executes one instruction per `w` request through a multicycle control FSM.
- Adds AND/OR/compare operations, zero/negative flags, a done/busy handshake and a register debug read port.
- The internal bus is a one-hot-selected mux (no tristates).

Parameters:
- WIDTH, 8, datapath and register width (>=2).
- NREGS, 8, number of general registers; power of two, >=2.
- RSEL_W is a derived localparam, clog2(NREGS), and is not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- w  input  1  start request; sampled only in IDLE.
- func  input  3  opcode.
- rx  input  RSEL_W  destination / first operand register.
- ry  input  RSEL_W  second operand register.
- data  input  WIDTH  immediate for LOAD.
- dbg_sel  input  RSEL_W  debug register select.
- dbg_val  output  WIDTH  combinational value of R[dbg_sel].
- bus  output  WIDTH  current internal bus value.
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle pulse in the final state of an instruction.
- flag_z  output  1  last ALU result was zero.
- flag_n  output  1  last ALU result MSB.

Behaviour:
- Reset (reset==0 at a clk edge) forces the following, and has priority over everything:
  - state=IDLE.
  - All R[i]=0, A=0, G=0.
  - flag_z=0, flag_n=0.
  - Instruction latch=0.
  - done=0, busy=0.
- Reset mid-instruction aborts it; no register writeback occurs at that edge.
- Opcodes:
  - 000 LOAD R[rx]=data.
  - 001 MOVE R[rx]=R[ry].
  - 010 ADD R[rx]=R[rx]+R[ry].
  - 011 SUB R[rx]=R[rx]-R[ry].
  - 100 XOR.
  - 101 AND.
  - 110 OR.
  - 111 CMP: computes R[rx]-R[ry], updates flags only, no writeback.
- IDLE: bus=0. On an edge with w=1, latch func/rx/ry/data and go to T1. Later changes on the inputs are ignored until the next IDLE.
- T1:
  - LOAD: bus=latched data; R[rx]<=bus at end of T1; done=1; next IDLE.
  - MOVE: bus=R[ry]; R[rx]<=bus; done=1; next IDLE.
  - ALU ops and CMP: bus=R[rx]; A<=bus; next T2.
- T2: bus=R[ry]; G<=A op bus; flag_z<=(result==0); flag_n<=result[WIDTH-1]; next T3.
- T3: bus=G.
  - Non-CMP: R[rx]<=bus.
  - CMP: no write.
  - done=1; next IDLE.
- Latency, with w sampled at edge k:
  - LOAD/MOVE: done high during cycle k+1; register updated at edge k+2.
  - ALU ops: done high during cycle k+3; register updated at edge k+4.
- Arithmetic:
  - Modulo 2^WIDTH; carry/overflow discarded.
  - SUB/CMP are computed as A + ~bus + 1.
  - Only ALU ops and CMP update the flags; LOAD/MOVE leave them unchanged.
- rx==ry is legal and uses the pre-instruction value for both operands (ADD r,r doubles; SUB r,r gives 0 with flag_z=1).
- w held high continuously: the next instruction is accepted at the first IDLE edge, giving one IDLE cycle between instructions. w during a non-IDLE state is ignored and not queued.
- dbg_val and bus are purely combinational from current state/registers; a write becomes visible the cycle after its edge.
- busy=1 exactly in T1/T2/T3; done is never high in IDLE or T2.

Test Plan:
- Reset/basic (WIDTH=8, NREGS=4):
  - Hold reset=0 for 2 cycles with w=1 -> all dbg_val reads 0, busy=0, done=0, flags 0.
  - Release reset, then LOAD r2,0x5A -> done at cycle k+1; dbg_sel=2 shows 0x5A from cycle k+2.
- Arithmetic:
  - R0=0xF0, R1=0x20; ADD r0,r1 -> R0=0x10 (wrap), done at cycle k+3, flag_z=0, flag_n=0.
  - SUB r1,r1 -> R1=0x00, flag_z=1.
- Compare/logic:
  - R0=0x10, R1=0x20; CMP r0,r1 -> R0 still 0x10, flag_n=1, flag_z=0.
  - XOR r0,r0 -> 0x00; AND 0xCC,0xAA -> 0x88; OR -> 0xEE.
- MOVE and flags:
  - R3=0x7F; MOVE r0,r3 -> R0=0x7F at k+2; flags unchanged from the prior ALU op.
  - Bus trace shows 0x7F in T1.
- Handshake: toggle w and func every cycle during an ADD -> only the first instruction executes; operands are from the latch; w is accepted again only after IDLE.
- Abort: assert reset in T2 of ADD r1,r2 -> R1 unchanged (0), state IDLE, done never pulses, busy=0 next cycle.
